mod3_frame_arbiter: RTL and testbench
=====================================

# mod3_frame_arbiter

Round-robin controller that shares one bit-serial divisible-by-3 residue engine among NREQ requesters. Each requester hands over a parallel WIDTH-bit word. The block serialises the word MSB-first into the engine using start/stop framing, samples the engine's one-bit verdict, and returns it tagged with the requester index. It sits between requester logic and the engine's clk/start/stop/data/result pins; the engine itself stays outside this block.

## Interface
- NREQ, 4: number of requesters, 2..16
- WIDTH, 8: word length in bits, 2..32 (WIDTH=1 is illegal: start and stop would share one cycle)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- req_valid  in  NREQ  per-requester word-valid
- req_word  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
- eng_start  out  1  engine frame start, high with the first bit
- eng_stop  out  1  engine frame stop, high with the last bit
- eng_data  out  1  serial bit to engine
- eng_result  in  1  engine verdict, valid the cycle after eng_stop
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  $clog2(NREQ)  index of the answered requester
- rsp_div3  out  1  1 = word divisible by 3
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SHIFT, WAIT, RESP.
- IDLE: if any req_valid is high, choose requester g by round-robin, starting the search at last_grant+1 and wrapping. In the same cycle, req_ready = onehot(g) combinationally. On the clock edge, capture req_word[g] into the shift register, set bit counter = 0, set last_grant = g, and go to SHIFT. No req_ready is asserted outside IDLE.
- SHIFT: eng_data = shreg[WIDTH-1]. Shift left each cycle. eng_start = (cnt==0). eng_stop = (cnt==WIDTH-1). After WIDTH cycles, go to WAIT.
- WAIT: all eng_* outputs low. Register eng_result into rsp_div3 and go to RESP.
- RESP: rsp_valid = 1 with rsp_id = last_grant. Go to IDLE.
- Engine contract: the residue clears on eng_start, and eng_result is registered on the edge that ends the eng_stop cycle.
- Requesters that are not granted keep req_valid and req_word stable. A requester may drop req_valid at any time while it is not being accepted.
- Reset values: req_ready = 0, eng_start/eng_stop/eng_data = 0, rsp_valid = 0, rsp_id = 0, rsp_div3 = 0, busy = 0, state = IDLE, last_grant = NREQ-1 (so requester 0 wins first).
- Reset mid-frame: return to IDLE on the next edge. The in-flight word is dropped with no response. The engine frame is abandoned, and the next eng_start reinitialises the engine.

## Timing
- Call the accept cycle T. Bits are driven in cycles T+1..T+WIDTH. eng_result is sampled in T+WIDTH+1. rsp_valid is high in T+WIDTH+2.
- Frame period is WIDTH+3 cycles. With continuous traffic, the next accept happens in T+WIDTH+3.
- At most one response is outstanding at a time. rsp_* outputs are registered. rsp_id and rsp_div3 hold their values until the next RESP.
- Fairness: each continuously-valid requester is served within NREQ frames.

## Configuration
- MOD3_ARB_CHECK_EN defined: the block adds an internal shadow residue (2-bit, next = (2*r + bit) mod 3) that updates during SHIFT, plus an output port chk_err (1 bit, reset 0). chk_err pulses in the RESP cycle when (shadow==0) != rsp_div3. rsp_div3 still reports the engine value.
- MOD3_ARB_CHECK_EN undefined: no shadow logic and no chk_err port.

## Test plan
- WIDTH=8, only req_valid[0] with word 8'h09: req_ready[0] in T, eng_data 0,0,0,0,1,0,0,1 over T+1..T+8, start at T+1, stop at T+8. With the behavioural engine, rsp_valid at T+10 with rsp_id=0, rsp_div3=1.
- Word 8'h0A on requester 2: rsp_id=2, rsp_div3=0. Word 8'hFF: rsp_div3=1. Word 8'h00: rsp_div3=1.
- All four req_valid held high from reset: grant order 0,1,2,3,0, one accept every 11 cycles, each ready a single-cycle one-hot pulse.
- req_valid[1] held high continuously with req_valid[3] raised mid-frame: the next grant goes to 3 only if 3 is next after last_grant; service alternates 1,3,1,3.
- rst_n low for one cycle at T+4 of a frame: next cycle busy=0, all eng_* = 0, no rsp_valid. A subsequent request completes correctly.
- With MOD3_ARB_CHECK_EN, force eng_result inverted for word 8'h03: chk_err=1 in the RESP cycle. With the normal engine, chk_err stays 0 over 1000 random words.

Source files
------------

// File: rtl/mod3_frame_arbiter.sv
// Round-robin arbiter sharing one bit-serial divisible-by-3 engine among NREQ requesters.
// Define MOD3_ARB_CHECK_EN to add a shadow residue check and the chk_err output.
module mod3_frame_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_word,
  output logic [NREQ-1:0]           req_ready,
  output logic                      eng_start,
  output logic                      eng_stop,
  output logic                      eng_data,
  input  logic                      eng_result,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_div3,
`ifdef MOD3_ARB_CHECK_EN
  output logic                      chk_err,
`endif
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant;
  logic             grant_any;
  int               idx;

`ifdef MOD3_ARB_CHECK_EN
  logic [1:0] shadow;

  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] nxt;
    case ({r, b})
      3'b000:  nxt = 2'd0;
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b011:  nxt = 2'd0;
      3'b100:  nxt = 2'd1;
      3'b101:  nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction
`endif

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    grant     = last_grant;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  // Ready is gated by rst_n so no handshake appears while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      last_grant <= IDW'(NREQ - 1);
      eng_start  <= 1'b0;
      eng_stop   <= 1'b0;
      eng_data   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_div3   <= 1'b0;
      busy       <= 1'b0;
`ifdef MOD3_ARB_CHECK_EN
      shadow     <= 2'd0;
      chk_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            shreg      <= req_word[int'(grant)*WIDTH +: WIDTH];
            eng_data   <= req_word[int'(grant)*WIDTH + WIDTH - 1];
            eng_start  <= 1'b1;
            eng_stop   <= 1'b0;
            cnt        <= '0;
            last_grant <= grant;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        // eng_data always mirrors shreg[WIDTH-1] while shifting.
        SHIFT: begin
`ifdef MOD3_ARB_CHECK_EN
          shadow <= mod3_step((cnt == '0) ? 2'd0 : shadow, eng_data);
`endif
          shreg     <= shreg << 1;
          eng_start <= 1'b0;
          if (cnt == CW'(WIDTH - 1)) begin
            eng_data <= 1'b0;
            eng_stop <= 1'b0;
            state    <= WAIT;
          end else begin
            eng_data <= shreg[WIDTH-2];
            eng_stop <= (cnt == CW'(WIDTH - 2));
            cnt      <= cnt + 1'b1;
          end
        end
        WAIT: begin
          rsp_div3  <= eng_result;
          rsp_id    <= last_grant;
          rsp_valid <= 1'b1;
`ifdef MOD3_ARB_CHECK_EN
          chk_err   <= ((shadow == 2'd0) != eng_result);
`endif
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
`ifdef MOD3_ARB_CHECK_EN
          chk_err   <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod3_frame_arbiter.sv
// Self-checking bench for mod3_frame_arbiter with a behavioural mod-3 engine.
// Define MOD3_ARB_CHECK_EN to also exercise the shadow residue check.
module tb_mod3_frame_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int FRAME = WIDTH + 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*WIDTH-1:0]   req_word = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    eng_start, eng_stop, eng_data;
  logic                    eng_result = 1'b0;
  logic                    rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic                    rsp_div3;
  logic                    busy;
`ifdef MOD3_ARB_CHECK_EN
  logic                    chk_err;
`endif

  int errors = 0;
  int checks = 0;
  int model_last = NREQ - 1;

  mod3_frame_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_word(req_word), .req_ready(req_ready),
    .eng_start(eng_start), .eng_stop(eng_stop), .eng_data(eng_data),
    .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_div3(rsp_div3),
`ifdef MOD3_ARB_CHECK_EN
    .chk_err(chk_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural engine: residue clears on start, verdict registered at the end of the stop cycle.
  int   eng_r = 0;
  logic eng_invert = 1'b0;

  function automatic int eng_step(input int r, input logic st, input logic b);
    return st ? int'(b) : (2 * r + int'(b)) % 3;
  endfunction

  always @(posedge clk) begin
    eng_r <= eng_step(eng_r, eng_start, eng_data);
    if (eng_stop) eng_result <= (eng_step(eng_r, eng_start, eng_data) == 0) ^ eng_invert;
  end

  function automatic int rr_next(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic div3(input logic [WIDTH-1:0] w);
    return (w % 3) == 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
    checks++;
    if ({busy, eng_start, eng_stop, eng_data, rsp_valid, rsp_div3} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected 000000",
                         {busy, eng_start, eng_stop, eng_data, rsp_valid, rsp_div3});
    end
    checks++;
    if (rsp_id !== '0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, eng_start, eng_stop, eng_data, rsp_valid} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_release: got %b expected 00000",
                         {busy, eng_start, eng_stop, eng_data, rsp_valid});
    end
    model_last = NREQ - 1;
  endtask

  task automatic test_single(input int id, input logic [WIDTH-1:0] word);
    bit got;
    logic [NREQ-1:0] exp;
    @(posedge clk);
    #1 req_valid = '0;
    req_valid[id] = 1'b1;
    req_word[id*WIDTH +: WIDTH] = word;
    got = 0;
    for (int n = 0; n < 3 * FRAME && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("[TB] FAIL single_accept_timeout: got no ready, expected ready within %0d cycles", 3 * FRAME);
      req_valid = '0;
      return;
    end
    exp = '0;
    exp[id] = 1'b1;
    checks++;
    if (req_ready !== exp) begin errors++; $display("[TB] FAIL single_ready: got %b expected %b", req_ready, exp); end
    @(posedge clk);
    #1 req_valid = '0;
    for (int b = 1; b <= WIDTH; b++) begin
      @(negedge clk);
      checks++;
      if ({eng_start, eng_stop, eng_data} !== {b == 1, b == WIDTH, word[WIDTH-b]}) begin
        errors++; $display("[TB] FAIL single_bit%0d: got %b expected %b", b,
                           {eng_start, eng_stop, eng_data}, {b == 1, b == WIDTH, word[WIDTH-b]});
      end
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, eng_start, eng_stop, eng_data, busy} !== 5'b00001) begin
      errors++; $display("[TB] FAIL single_wait: got %b expected 00001",
                         {rsp_valid, eng_start, eng_stop, eng_data, busy});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_div3} !== {1'b1, 2'(id), div3(word)}) begin
      errors++; $display("[TB] FAIL single_resp: got v=%b id=%0d div3=%b expected v=1 id=%0d div3=%b",
                         rsp_valid, rsp_id, rsp_div3, id, div3(word));
    end
    model_last = id;
  endtask

  task automatic test_round_robin();
    int k, cyc, prev;
    bit got;
    logic [NREQ-1:0] exp;
    logic [WIDTH-1:0] w0;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_word[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    w0 = req_word[WIDTH-1:0];
    req_valid = '1;
    k = 0; cyc = 0; prev = 0;
    while (k < 5 && cyc < 8 * FRAME) begin
      @(negedge clk);
      cyc++;
      if (req_ready !== '0) begin
        exp = '0;
        exp[k % NREQ] = 1'b1;
        checks++;
        if (req_ready !== exp) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp); end
        if (k > 0) begin
          checks++;
          if (cyc - prev !== FRAME) begin errors++; $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", k, cyc - prev, FRAME); end
        end
        prev = cyc;
        k++;
      end
    end
    checks++;
    if (k !== 5) begin errors++; $display("[TB] FAIL rr_timeout: got %0d accepts expected 5", k); end
    @(posedge clk);
    #1 req_valid = '0;
    got = 0;
    for (int n = 0; n < 2 * FRAME && !got; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || rsp_id !== 0 || rsp_div3 !== div3(w0)) begin
      errors++; $display("[TB] FAIL rr_last_resp: got v=%b id=%0d div3=%b expected v=1 id=0 div3=%b",
                         got, rsp_id, rsp_div3, div3(w0));
    end
    model_last = 0;
  endtask

  task automatic test_alternate();
    int alt_exp[4] = '{1, 3, 1, 3};
    int k, cyc, first_acc;
    bit got;
    logic [NREQ-1:0] exp;
    logic [WIDTH-1:0] w3;
    @(posedge clk);
    #1 req_valid = '0;
    req_word[1*WIDTH +: WIDTH] = WIDTH'($urandom);
    req_word[3*WIDTH +: WIDTH] = WIDTH'($urandom);
    w3 = req_word[3*WIDTH +: WIDTH];
    req_valid[1] = 1'b1;
    k = 0; cyc = 0; first_acc = -1;
    while (k < 4 && cyc < 8 * FRAME) begin
      @(negedge clk);
      cyc++;
      if (req_ready !== '0) begin
        exp = '0;
        exp[alt_exp[k]] = 1'b1;
        checks++;
        if (req_ready !== exp) begin errors++; $display("[TB] FAIL alt_grant%0d: got %b expected %b", k, req_ready, exp); end
        if (k == 0) first_acc = cyc;
        k++;
      end
      @(posedge clk);
      #1;
      if (first_acc >= 0 && cyc == first_acc + 4) req_valid[3] = 1'b1;
      if (k == 4) req_valid = '0;
    end
    checks++;
    if (k !== 4) begin errors++; $display("[TB] FAIL alt_timeout: got %0d accepts expected 4", k); end
    req_valid = '0;
    got = 0;
    for (int n = 0; n < 2 * FRAME && !got; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || rsp_id !== 3 || rsp_div3 !== div3(w3)) begin
      errors++; $display("[TB] FAIL alt_last_resp: got v=%b id=%0d div3=%b expected v=1 id=3 div3=%b",
                         got, rsp_id, rsp_div3, div3(w3));
    end
    model_last = 3;
  endtask

  // Cycle-level model: one frame of FRAME cycles per accept, counted from the accept cycle.
  task automatic test_random(input int nframes);
    int since, accepts, cur_id, exp_g;
    logic [WIDTH-1:0] cur_word;
    logic [NREQ-1:0] exp_ready;
    logic exp_data;
    since = FRAME; accepts = 0; cur_id = 0; cur_word = '0;
    for (int cyc = 0; cyc < 4 * FRAME * nframes; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (accepts >= nframes) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(3) == 0) begin
            req_word[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
      end
      since++;
      @(negedge clk);
      exp_g = (since >= FRAME) ? rr_next(model_last, req_valid) : -1;
      exp_ready = '0;
      if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready: got %b expected %b", req_ready, exp_ready); end
      exp_data = (since >= 1 && since <= WIDTH) ? cur_word[WIDTH-since] : 1'b0;
      checks++;
      if ({busy, eng_start, eng_stop, eng_data, rsp_valid} !==
          {since >= 1 && since <= WIDTH + 2, since == 1, since == WIDTH, exp_data, since == WIDTH + 2}) begin
        errors++; $display("[TB] FAIL rand_frame: got %b expected %b at frame cycle %0d",
                           {busy, eng_start, eng_stop, eng_data, rsp_valid},
                           {since >= 1 && since <= WIDTH + 2, since == 1, since == WIDTH, exp_data, since == WIDTH + 2}, since);
      end
      if (since == WIDTH + 2) begin
        checks++;
        if (rsp_id !== 2'(cur_id) || rsp_div3 !== div3(cur_word)) begin
          errors++; $display("[TB] FAIL rand_resp: got id=%0d div3=%b expected id=%0d div3=%b",
                             rsp_id, rsp_div3, cur_id, div3(cur_word));
        end
        if (accepts >= nframes) break;
      end
      if (exp_g >= 0) begin
        since = 0;
        cur_id = exp_g;
        cur_word = req_word[exp_g*WIDTH +: WIDTH];
        model_last = exp_g;
        accepts++;
      end
    end
    checks++;
    if (accepts < nframes) begin errors++; $display("[TB] FAIL rand_timeout: got %0d accepts expected %0d", accepts, nframes); end
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    bit got;
    @(posedge clk);
    #1 req_valid = '0;
    req_valid[2] = 1'b1;
    req_word[2*WIDTH +: WIDTH] = 8'h5A;
    got = 0;
    for (int n = 0; n < 3 * FRAME && !got; n++) begin
      @(negedge clk);
      if (req_ready !== '0) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL midrst_accept_timeout: got no ready expected ready"); end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, eng_start, eng_stop, eng_data, rsp_valid} !== 5'b0 || rsp_id !== '0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got %b id=%0d expected 00000 id=0",
                         {busy, eng_start, eng_stop, eng_data, rsp_valid}, rsp_id);
    end
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_resp: got %b expected 0", rsp_valid); end
    end
    model_last = NREQ - 1;
  endtask

`ifdef MOD3_ARB_CHECK_EN
  task automatic test_check();
    bit got;
    int id;
    logic [WIDTH-1:0] w;
    eng_invert = 1'b1;
    for (int f = 0; f <= 1000; f++) begin
      id = (f == 0) ? 0 : int'($urandom_range(NREQ - 1));
      w  = (f == 0) ? 8'h03 : WIDTH'($urandom);
      @(posedge clk);
      #1 req_valid = '0;
      req_valid[id] = 1'b1;
      req_word[id*WIDTH +: WIDTH] = w;
      got = 0;
      for (int n = 0; n < 3 * FRAME && !got; n++) begin
        @(negedge clk);
        if (req_ready !== '0) got = 1;
      end
      @(posedge clk);
      #1 req_valid = '0;
      got = 0;
      for (int n = 0; n < 2 * FRAME && !got; n++) begin
        @(negedge clk);
        if (rsp_valid === 1'b1) got = 1;
        else if (f > 0) begin
          checks++;
          if (chk_err !== 1'b0) begin errors++; $display("[TB] FAIL chk_quiet: got %b expected 0", chk_err); end
        end
      end
      checks++;
      if (!got) begin errors++; $display("[TB] FAIL chk_timeout: got no rsp expected rsp"); end
      else if (f == 0) begin
        checks++;
        if (chk_err !== 1'b1 || rsp_div3 !== 1'b0) begin
          errors++; $display("[TB] FAIL chk_inverted: got chk_err=%b div3=%b expected chk_err=1 div3=0", chk_err, rsp_div3);
        end
        eng_invert = 1'b0;
      end else begin
        checks++;
        if (chk_err !== 1'b0 || rsp_div3 !== div3(w) || rsp_id !== 2'(id)) begin
          errors++; $display("[TB] FAIL chk_normal: got chk_err=%b div3=%b id=%0d expected chk_err=0 div3=%b id=%0d",
                             chk_err, rsp_div3, rsp_id, div3(w), id);
        end
      end
      model_last = id;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(0, 8'h09);
    test_single(2, 8'h0A);
    test_single(1, 8'hFF);
    test_single(3, 8'h00);
    test_round_robin();
    test_alternate();
    test_random(60);
    test_mid_reset();
    test_single(2, 8'h5A);
    test_single(1, 8'h03);
`ifdef MOD3_ARB_CHECK_EN
    test_check();
`endif
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
